serial_right_shifter: RTL and testbench



---
 rtl/serial_right_shifter.sv | 89 ++++++++
 tb/tb_serial_right_shifter.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/serial_right_shifter.sv
// serial_right_shifter: multi-cycle right shift / rotate, one bit per clock,
// with valid/ready handshakes on both the request and the result side.
module serial_right_shifter #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned SHAMT_WIDTH = 3
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_valid,
  output logic                   o_ready,
  input  logic [DATA_WIDTH-1:0]  i_data,
  input  logic [SHAMT_WIDTH-1:0] shift_amount,
  input  logic                   i_rotate,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic [DATA_WIDTH-1:0]  o_data,
  output logic                   o_busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                  state_q;
  state_t                  state_nxt;
  logic [DATA_WIDTH-1:0]   data_nxt;
  logic [SHAMT_WIDTH-1:0]  count_q;
  logic [SHAMT_WIDTH-1:0]  count_nxt;
  logic                    mode_q;
  logic                    mode_nxt;

  // Next-state, datapath and count update; everything holds by default.
  always_comb begin
    state_nxt = state_q;
    data_nxt  = o_data;
    count_nxt = count_q;
    mode_nxt  = mode_q;
    unique case (state_q)
      IDLE: begin
        if (i_valid) begin
          data_nxt  = i_data;
          count_nxt = shift_amount;
          mode_nxt  = i_rotate;
          state_nxt = (shift_amount == SHAMT_WIDTH'(0)) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        // MSB fill is the outgoing LSB when rotating, zero otherwise.
        data_nxt  = {(mode_q & o_data[0]), o_data[DATA_WIDTH-1:1]};
        count_nxt = count_q - SHAMT_WIDTH'(1);
        if (count_q == SHAMT_WIDTH'(1)) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (i_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State, datapath and handshake outputs, all registered from next state.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      o_data  <= '0;
      count_q <= '0;
      mode_q  <= 1'b0;
      o_ready <= 1'b1;
      o_valid <= 1'b0;
      o_busy  <= 1'b0;
    end else begin
      state_q <= state_nxt;
      o_data  <= data_nxt;
      count_q <= count_nxt;
      mode_q  <= mode_nxt;
      o_ready <= (state_nxt == IDLE);
      o_valid <= (state_nxt == DONE);
      o_busy  <= (state_nxt != IDLE);
    end
  end

endmodule

// File: tb/tb_serial_right_shifter.sv
// Directed and random checks of serial_right_shifter against hand-computed values.
module tb_serial_right_shifter;

  logic       i_clk = 1'b0;
  logic       i_rst;
  logic       i_valid;
  logic       o_ready;
  logic [7:0] i_data;
  logic [2:0] shift_amount;
  logic       i_rotate;
  logic       o_valid;
  logic       i_ready;
  logic [7:0] o_data;
  logic       o_busy;

  int n_checks = 0;
  int n_fail   = 0;

  serial_right_shifter #(.DATA_WIDTH(8), .SHAMT_WIDTH(3)) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_valid      (i_valid),
    .o_ready      (o_ready),
    .i_data       (i_data),
    .shift_amount (shift_amount),
    .i_rotate     (i_rotate),
    .o_valid      (o_valid),
    .i_ready      (i_ready),
    .o_data       (o_data),
    .o_busy       (o_busy)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // Drive garbage on the request side while the block must ignore it.
  task automatic noise_inputs(input bit en);
    i_valid = en;
    if (en) begin
      i_data       = 8'($urandom);
      shift_amount = 3'($urandom);
      i_rotate     = 1'($urandom);
    end
  endtask

  // One request with expected result/latency, optional DONE stall and input noise.
  task automatic do_req(input string tag, input logic [7:0] d, input logic [2:0] n,
                        input logic r, input logic [7:0] exp, input int stall,
                        input bit noise);
    int cyc;
    check({tag, "_ready_in"}, 32'(o_ready), 32'd1);
    i_valid      = 1'b1;
    i_data       = d;
    shift_amount = n;
    i_rotate     = r;
    i_ready      = (stall == 0);
    tick();
    noise_inputs(noise);
    if (n != 3'd0) begin
      check({tag, "_busy"}, 32'({o_busy, o_ready, o_valid}), 32'b100);
    end
    cyc = 0;
    while (o_valid !== 1'b1 && cyc < 12) begin
      tick();
      noise_inputs(noise);
      cyc++;
    end
    check({tag, "_lat"}, 32'(cyc), 32'(n));
    check({tag, "_data"}, 32'(o_data), 32'(exp));
    check({tag, "_done_ready"}, 32'(o_ready), 32'd0);
    for (int s = 0; s < stall; s++) begin
      tick();
      noise_inputs(noise);
      check({tag, "_stall_flags"}, 32'({o_valid, o_ready, o_busy}), 32'b101);
      check({tag, "_stall_data"}, 32'(o_data), 32'(exp));
    end
    i_ready = 1'b1;
    tick();
    i_valid = 1'b0;
    check({tag, "_handoff"}, 32'({o_valid, o_ready, o_busy}), 32'b010);
  endtask

  // Reference model: right shift or rotate of an 8-bit word.
  function automatic logic [7:0] model(input logic [7:0] d, input logic [2:0] n, input logic r);
    logic [15:0] dd;
    dd = {d, d} >> n;
    return r ? dd[7:0] : (d >> n);
  endfunction

  initial begin
    logic [7:0] rd;
    logic [2:0] rn;
    logic       rr;
    i_rst = 1'b1; i_valid = 1'b0; i_data = 8'h00; shift_amount = 3'd0;
    i_rotate = 1'b0; i_ready = 1'b0;
    tick();
    tick();
    i_rst = 1'b0;
    check("reset_flags", 32'({o_ready, o_valid, o_busy}), 32'b100);
    check("reset_data", 32'(o_data), 32'h00);

    do_req("lsr_b4_3", 8'hB4, 3'd3, 1'b0, 8'h16, 0, 1'b0);
    do_req("ror_b4_3", 8'hB4, 3'd3, 1'b1, 8'h96, 0, 1'b0);
    do_req("round_trip", 8'h8B, 3'd5, 1'b1, 8'h5C, 0, 1'b0);
    do_req("amt0", 8'h5A, 3'd0, 1'b0, 8'h5A, 0, 1'b0);
    do_req("lsr_80_7", 8'h80, 3'd7, 1'b0, 8'h01, 0, 1'b0);
    do_req("ror_01_7", 8'h01, 3'd7, 1'b1, 8'h02, 0, 1'b0);
    do_req("backpressure", 8'hC3, 3'd4, 1'b1, 8'h3C, 5, 1'b1);
    do_req("bp_amt0", 8'hE7, 3'd0, 1'b1, 8'hE7, 3, 1'b1);

    // Reset in the middle of a shift discards the operation.
    i_valid = 1'b1; i_data = 8'hFF; shift_amount = 3'd6; i_rotate = 1'b0; i_ready = 1'b1;
    tick();
    i_valid = 1'b0;
    tick();
    tick();
    check("mid_busy", 32'(o_busy), 32'd1);
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    check("mid_rst_flags", 32'({o_ready, o_valid, o_busy}), 32'b100);
    check("mid_rst_data", 32'(o_data), 32'h00);

    // Reset and a request on the same edge: request must be dropped.
    i_rst = 1'b1; i_valid = 1'b1; i_data = 8'hAA; shift_amount = 3'd2;
    tick();
    i_rst = 1'b0; i_valid = 1'b0;
    check("rst_req_flags", 32'({o_ready, o_valid, o_busy}), 32'b100);
    check("rst_req_data", 32'(o_data), 32'h00);
    tick();
    check("rst_req_idle", 32'({o_ready, o_busy}), 32'b10);

    do_req("after_rst", 8'h0F, 3'd2, 1'b0, 8'h03, 0, 1'b0);

    for (int k = 0; k < 100; k++) begin
      rd = 8'($urandom);
      rn = 3'($urandom);
      rr = 1'($urandom);
      do_req($sformatf("rand%0d", k), rd, rn, rr, model(rd, rn, rr),
             int'($urandom_range(0, 2)), 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
